// File: rtl/nor_flash_responder_pkg.sv
// Shared command opcodes, mode/operation encodings and status-register layout
// for the NOR flash responder.
package nor_flash_responder_pkg;

    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] CMD_READ_ID     = 8'h90;
    localparam logic [7:0] CMD_CLR_STATUS  = 8'h50;
    localparam logic [7:0] CMD_PROG        = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
    localparam logic [7:0] CMD_ERASE       = 8'h20;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;

    typedef enum logic [2:0] {
        MODE_ARRAY,
        MODE_STATUS,
        MODE_ID,
        MODE_PROG_SETUP,
        MODE_ERASE_SETUP
    } mode_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PROG,
        OP_ERASE
    } op_t;

    function automatic logic [7:0] make_status(input logic ready, input logic erase_err,
                                               input logic prog_err);
        logic [7:0] s;
        s               = '0;
        s[SR_READY]     = ready;
        s[SR_ERASE_ERR] = erase_err;
        s[SR_PROG_ERR]  = prog_err;
        return s;
    endfunction

endpackage

// File: rtl/nor_flash_responder_array.sv
// Single-port word array with registered read. Words are stored inverted so
// that all-zero power-up content reads back as erased (16'hFFFF).
module nor_flash_responder_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    localparam int DEPTH = 2 ** AW;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= ~wdata;
        end
        rdata <= ~mem[addr];
    end

endmodule

// File: rtl/nor_flash_responder.sv
// Device end of the NOR bus: decodes ce/we/oe command cycles and answers reads
// with array data, status or ID like a StrataFlash-style part.
module nor_flash_responder
    import nor_flash_responder_pkg::*;
#(
    parameter int          AW          = 8,
    parameter int          ACC_CYCLES  = 4,
    parameter int          PROG_CYCLES = 16,
    parameter logic [15:0] MFR_ID      = 16'h0089,
    parameter logic [15:0] DEV_ID      = 16'h8919
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        we,
    input  logic        oe,
    input  logic [23:0] addr,
    inout  wire  [15:0] data,
    output logic        busy,
    output logic [7:0]  status
);
    localparam int ACW = $clog2(ACC_CYCLES + 1);
    localparam int PCW = $clog2(PROG_CYCLES + 1);

    mode_t          mode;
    op_t            op;
    logic           sr5, sr4;
    logic [PCW-1:0] prog_cnt;
    logic [AW-1:0]  walk_addr, prog_addr;
    logic [15:0]    prog_data;
    logic           wr_q;
    logic [23:0]    wr_addr_q;
    logic [15:0]    wr_data_q;
    logic [ACW-1:0] acc_cnt;

    logic           commit;
    logic [7:0]     opcode;
    logic           addr_oor;
    logic           arr_we;
    logic [AW-1:0]  arr_addr;
    logic [15:0]    arr_wdata, arr_rdata;
    logic [15:0]    rd_val;
    logic           drive;

    assign busy     = (op != OP_IDLE);
    assign status   = make_status(~busy, sr5, sr4);
    assign commit   = wr_q & we;
    assign opcode   = wr_data_q[7:0];
    assign addr_oor = |wr_addr_q[23:AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= MODE_ARRAY;
            op        <= OP_IDLE;
            sr5       <= 1'b0;
            sr4       <= 1'b0;
            prog_cnt  <= '0;
            walk_addr <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            acc_cnt   <= '0;
        end else begin
            wr_q <= ~ce & ~we;
            if (~ce & ~we) begin
                wr_addr_q <= addr;
                wr_data_q <= data;
            end

            if (~ce & ~oe & we) begin
                if (acc_cnt != ACW'(ACC_CYCLES)) acc_cnt <= acc_cnt + ACW'(1);
            end else begin
                acc_cnt <= '0;
            end

            case (op)
                OP_PROG: begin
                    prog_cnt <= prog_cnt - PCW'(1);
                    if (prog_cnt == PCW'(1)) op <= OP_IDLE;
                end
                OP_ERASE: begin
                    walk_addr <= walk_addr + AW'(1);
                    if (&walk_addr) op <= OP_IDLE;
                end
                default: ;
            endcase

            // Commits arriving while an operation runs are dropped entirely.
            if (commit && op == OP_IDLE) begin
                case (mode)
                    MODE_PROG_SETUP: begin
                        mode <= MODE_STATUS;
                        if (addr_oor) begin
                            sr4 <= 1'b1;
                        end else begin
                            op        <= OP_PROG;
                            prog_cnt  <= PCW'(PROG_CYCLES);
                            prog_addr <= wr_addr_q[AW-1:0];
                            prog_data <= wr_data_q;
                        end
                    end
                    MODE_ERASE_SETUP: begin
                        mode <= MODE_STATUS;
                        if (opcode == CMD_CONFIRM) begin
                            op        <= OP_ERASE;
                            walk_addr <= '0;
                        end else begin
                            sr5 <= 1'b1;
                            sr4 <= 1'b1;
                        end
                    end
                    default: begin
                        case (opcode)
                            CMD_READ_ARRAY:         mode <= MODE_ARRAY;
                            CMD_READ_STATUS:        mode <= MODE_STATUS;
                            CMD_READ_ID:            mode <= MODE_ID;
                            CMD_CLR_STATUS: begin
                                sr5 <= 1'b0;
                                sr4 <= 1'b0;
                            end
                            CMD_PROG, CMD_PROG_ALT: mode <= MODE_PROG_SETUP;
                            CMD_ERASE:              mode <= MODE_ERASE_SETUP;
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    // Program is read-modify-write: first busy clock reads the old word, second writes the AND.
    assign arr_we    = (op == OP_ERASE) ||
                       (op == OP_PROG && prog_cnt == PCW'(PROG_CYCLES - 1));
    assign arr_addr  = (op == OP_ERASE) ? walk_addr :
                       (op == OP_PROG)  ? prog_addr : addr[AW-1:0];
    assign arr_wdata = (op == OP_ERASE) ? 16'hFFFF : (arr_rdata & prog_data);

    nor_flash_responder_array #(.AW(AW)) u_array (
        .clk   (clk),
        .wr_en (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_comb begin
        rd_val = {8'h00, status};
        if (!busy) begin
            case (mode)
                MODE_ARRAY: rd_val = arr_rdata;
                MODE_ID: begin
                    if (addr[7:0] == 8'd0)      rd_val = MFR_ID;
                    else if (addr[7:0] == 8'd1) rd_val = DEV_ID;
                    else                        rd_val = 16'h0000;
                end
                default: ;
            endcase
        end
    end

    // Release follows the counter clear, so the bus goes Z the clock after ce/oe rise.
    assign drive = (acc_cnt == ACW'(ACC_CYCLES)) & we;
    assign data  = drive ? rd_val : 16'hzzzz;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed bench for nor_flash_responder: expected read data is queued when a
// read is launched and popped when the bus is sampled.
module tb_nor_flash_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce, we, oe;
    logic [23:0] addr;
    wire  [15:0] data;
    logic        busy;
    logic [7:0]  status;
    logic        drv_en;
    logic [15:0] drv_val;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    assign data = drv_en ? drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    nor_flash_responder dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .we     (we),
        .oe     (oe),
        .addr   (addr),
        .data   (data),
        .busy   (busy),
        .status (status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_sb(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, data);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'h0000, data}, {16'h0000, e});
        end
    endtask

    // An undriven bus may resolve to z or to 0 depending on the simulator.
    task automatic chk_z(input string tag);
        checks++;
        assert (data === 16'hzzzz || data === 16'h0000) else begin
            failures++;
            $error("FAIL %s observed=%h expected=zzzz", tag, data);
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        addr = a; drv_val = d; drv_en = 1'b1;
        ce = 1'b0; we = 1'b0; oe = 1'b1;
        tick();
        we = 1'b1; ce = 1'b1; drv_en = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [23:0] a, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        addr = a; ce = 1'b0; oe = 1'b0; we = 1'b1;
        repeat (3) tick();
        chk_z({tag, "_early"});
        tick();
        chk_sb(tag);
        ce = 1'b1; oe = 1'b1;
        tick();
        chk_z({tag, "_release"});
    endtask

    // Hold a status read across a busy period; cyc = clocks from call until ready.
    task automatic poll(input int cyc, input string tag);
        int n;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0080);
        addr = '0; ce = 1'b0; oe = 1'b0; we = 1'b1;
        repeat (4) tick();
        chk_sb({tag, "_busy"});
        n = 4;
        while (busy && n < cyc + 64) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, n, cyc);
        chk_sb({tag, "_ready"});
        ce = 1'b1; oe = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        reset = 1'b1; ce = 1'b1; we = 1'b1; oe = 1'b1;
        addr = '0; drv_en = 1'b0; drv_val = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 8'h80);
        chk_z("rst_data");

        wr(0, 16'h0070);
        rd(0, 16'h0080, "read_status");

        wr(0, 16'h0090);
        rd(0, 16'h0089, "mfr_id");
        rd(24'h000101, 16'h8919, "dev_id");
        rd(2, 16'h0000, "id_other");

        wr(0, 16'h00FF);
        rd(0, 16'hFFFF, "array_init");

        wr(0, 16'h0040);
        wr(5, 16'h1234);
        poll(16, "prog5");
        wr(0, 16'h00FF);
        rd(5, 16'h1234, "array5");
        wr(0, 16'h0010);
        wr(5, 16'hFF00);
        poll(16, "reprog5");
        wr(0, 16'h00FF);
        rd(5, 16'h1200, "array5_and");

        wr(0, 16'h0020);
        wr(0, 16'h00AA);
        rd(0, 16'h00B0, "seq_err");
        wr(0, 16'h0050);
        rd(0, 16'h0080, "clr_status");

        wr(0, 16'h0040);
        wr(24'h3F0000, 16'h0000);
        chk("oor_busy", busy, 0);
        rd(0, 16'h0090, "oor_status");
        wr(0, 16'h0050);

        wr(0, 16'h0040);
        wr(6, 16'h5A5A);
        wr(0, 16'h00FF);
        poll(14, "busy_ignore");
        rd(0, 16'h0080, "still_status");
        wr(0, 16'h00FF);
        rd(6, 16'h5A5A, "array6");
        rd(0, 16'hFFFF, "array0_kept");

        wr(0, 16'h0040);
        wr(200, 16'h00F0);
        poll(16, "prog200");
        wr(0, 16'h0020);
        wr(0, 16'h00D0);
        chk("erase_busy", busy, 1);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_status", status, 8'h80);
        rd(200, 16'h00F0, "abort_kept200");
        rd(5, 16'hFFFF, "abort_erased5");
        rd(6, 16'hFFFF, "abort_erased6");

        ce = 1'b0; we = 1'b0; oe = 1'b0; drv_en = 1'b0;
        repeat (6) tick();
        chk_z("write_wins");
        we = 1'b1; ce = 1'b1; oe = 1'b1;
        tick();

        wr(0, 16'h0040);
        wr(7, 16'h0000);
        poll(16, "prog7");
        wr(0, 16'h0020);
        wr(0, 16'h00D0);
        poll(256, "erase_all");
        wr(0, 16'h00FF);
        addr = '0; ce = 1'b0; oe = 1'b0; we = 1'b1;
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (data !== 16'hFFFF) bad++;
            addr = 24'(i + 1);
            tick();
        end
        chk("erase_sweep_bad", bad, 0);
        ce = 1'b1; oe = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
